univ_shift_reg: RTL and testbench
=================================

Name: univ_shift_reg

Overview:
Parametrised universal shift register, the multi-bit successor to the single-bit positive-edge D flip-flop. Holds a WIDTH-bit word and, each rising clock edge, performs one of eight operations: hold, parallel load, logical shift, rotate, arithmetic shift or clear. A saturating shift counter with a Done flag lets it act directly as a parallel-to-serial or serial-to-parallel converter in datapath and UART-style serialiser designs.

Parameters:
WIDTH, 8, register width in bits; legal range WIDTH >= 2.
RESET_VAL, 0, value loaded into Q on reset and by the CLR mode; WIDTH bits.
CW, $clog2(WIDTH+1), width of Cnt; derived, not overridden.

Ports:
En  input  1  clock; all state updates on posedge En.
Reset_n  input  1  synchronous active-low reset, sampled on posedge En.
Mode  input  3  operation select; see Behaviour.
D  input  WIDTH  parallel load data.
SI_L  input  1  serial in for left shift; enters Q[0].
SI_R  input  1  serial in for right shift; enters Q[WIDTH-1].
Q  output  WIDTH  registered word.
SO_L  output  1  Q[WIDTH-1], combinational from Q; the bit that leaves on SHL.
SO_R  output  1  Q[0], combinational from Q; the bit that leaves on SHR or ASR.
Cnt  output  CW  number of shift or rotate ops since last LOAD, CLR or reset; saturates at WIDTH.
Done  output  1  high when Cnt == WIDTH; combinational from Cnt.

Behaviour:
- One clock (En); reset is synchronous and active-low (Reset_n). No asynchronous paths; no other edges used.
- Reset: when Reset_n=0 at posedge En, Q<=RESET_VAL and Cnt<=0, so Done=0. Reset overrides every Mode, including in the middle of a serialisation sequence. Outputs are undefined only before the first reset edge.
- Mode encoding, applied at posedge En when Reset_n=1:
  - 000 HOLD: Q and Cnt unchanged.
  - 001 LOAD: Q<=D; Cnt<=0.
  - 010 SHL: Q<={Q[W-2:0],SI_L}.
  - 011 SHR: Q<={SI_R,Q[W-1:1]}.
  - 100 ROL: Q<={Q[W-2:0],Q[W-1]}.
  - 101 ROR: Q<={Q[0],Q[W-1:1]}.
  - 110 ASR: Q<={Q[W-1],Q[W-1:1]}; the sign bit is replicated and SI_R is ignored.
  - 111 CLR: Q<=RESET_VAL; Cnt<=0.
- Counter: modes 010-110 increment Cnt by 1 if Cnt<WIDTH; otherwise Cnt holds at WIDTH and does not wrap. The shift itself still occurs when Cnt is saturated.
- Latency: Q, Cnt and Done reflect an operation one edge after Mode is sampled. SO_L and SO_R track Q with no added delay.
- Mode or D changing between edges has no effect. Only the value present at posedge is used.
- Serial inputs SI_L and SI_R are ignored in every mode except their own shift.
- Unknown or X Mode is a bench error and is not handled specially in RTL beyond default HOLD.

Test Plan:
1. WIDTH=8, RESET_VAL=8'hA5: Reset_n=0 for 1 edge -> Q=8'hA5, Cnt=0, Done=0. Then Mode=CLR -> Q=8'hA5, Cnt=0.
2. LOAD D=8'b1011_0010, then 8x SHR with SI_R=0 -> SO_R sequence before each edge is 0,1,0,0,1,1,0,1; after the 8th edge Q=8'h00, Cnt=8, Done=1. A 9th SHR -> Cnt stays 8.
3. LOAD 8'h81, ROL x1 -> Q=8'h03. ROR x2 -> Q=8'hC0. Cnt=3.
4. LOAD 8'h90, ASR x3 -> Q=8'h90, then 8'hC8, 8'hE4, 8'hF2. LOAD 8'h70, ASR x1 -> Q=8'h38.
5. Serial-in: CLR with RESET_VAL=0, then SHL x8 with SI_L sequence 1,1,0,0,1,0,1,0 -> Q=8'hCA, Done=1. HOLD for 3 edges -> Q and Cnt unchanged.
6. Mid-sequence reset: LOAD 8'hFF, SHL x4, then Reset_n=0 together with Mode=SHL -> Q=RESET_VAL, Cnt=0. LOAD on the next edge -> Q=D, Cnt=0.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, load, shift, rotate, arithmetic shift and clear,
// with a saturating shift counter for parallel/serial conversion.
module univ_shift_reg #(
  parameter int unsigned          WIDTH     = 8,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0,
  localparam int unsigned         CW        = $clog2(WIDTH + 1)
) (
  input  logic             En,
  input  logic             Reset_n,
  input  logic [2:0]       Mode,
  input  logic [WIDTH-1:0] D,
  input  logic             SI_L,
  input  logic             SI_R,
  output logic [WIDTH-1:0] Q,
  output logic             SO_L,
  output logic             SO_R,
  output logic [CW-1:0]    Cnt,
  output logic             Done
);

  typedef enum logic [2:0] {
    ModeHold = 3'b000,
    ModeLoad = 3'b001,
    ModeShl  = 3'b010,
    ModeShr  = 3'b011,
    ModeRol  = 3'b100,
    ModeRor  = 3'b101,
    ModeAsr  = 3'b110,
    ModeClr  = 3'b111
  } mode_e;

  localparam logic [CW-1:0] CntMax = CW'(WIDTH);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             shift_op;
  mode_e            mode;

  assign mode = mode_e'(Mode);

  always_comb begin
    q_d      = q_q;
    cnt_d    = cnt_q;
    shift_op = 1'b0;
    unique case (mode)
      ModeHold: ;
      ModeLoad: begin
        q_d   = D;
        cnt_d = '0;
      end
      ModeShl: begin
        q_d      = {q_q[WIDTH-2:0], SI_L};
        shift_op = 1'b1;
      end
      ModeShr: begin
        q_d      = {SI_R, q_q[WIDTH-1:1]};
        shift_op = 1'b1;
      end
      ModeRol: begin
        q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        shift_op = 1'b1;
      end
      ModeRor: begin
        q_d      = {q_q[0], q_q[WIDTH-1:1]};
        shift_op = 1'b1;
      end
      ModeAsr: begin
        q_d      = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        shift_op = 1'b1;
      end
      ModeClr: begin
        q_d   = RESET_VAL;
        cnt_d = '0;
      end
      default: ;
    endcase
    // Counter saturates at WIDTH; the shift itself still happens.
    if (shift_op && (cnt_q < CntMax)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge En) begin
    if (!Reset_n) begin
      q_q   <= RESET_VAL;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign Q    = q_q;
  assign SO_L = q_q[WIDTH-1];
  assign SO_R = q_q[0];
  assign Cnt  = cnt_q;
  assign Done = (cnt_q == CntMax);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: two instances (RESET_VAL A5 and 00) share stimulus.
module tb_univ_shift_reg;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = $clog2(W + 1);

  localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011;
  localparam logic [2:0] ROL  = 3'b100, ROR  = 3'b101, ASR = 3'b110, CLR = 3'b111;

  logic          en = 1'b0;
  logic          reset_n;
  logic [2:0]    mode;
  logic [W-1:0]  d;
  logic          si_l, si_r;

  logic [W-1:0]  q_a, q_z;
  logic          so_l_a, so_r_a, so_l_z, so_r_z;
  logic [CW-1:0] cnt_a, cnt_z;
  logic          done_a, done_z;

  int vectors = 0;
  int errors  = 0;

  univ_shift_reg #(.WIDTH(W), .RESET_VAL(8'hA5)) dut_a (
    .En(en), .Reset_n(reset_n), .Mode(mode), .D(d), .SI_L(si_l), .SI_R(si_r),
    .Q(q_a), .SO_L(so_l_a), .SO_R(so_r_a), .Cnt(cnt_a), .Done(done_a)
  );

  univ_shift_reg #(.WIDTH(W), .RESET_VAL(8'h00)) dut_z (
    .En(en), .Reset_n(reset_n), .Mode(mode), .D(d), .SI_L(si_l), .SI_R(si_r),
    .Q(q_z), .SO_L(so_l_z), .SO_R(so_r_z), .Cnt(cnt_z), .Done(done_z)
  );

  always #5 en = ~en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one operation, then sample 1 time unit after the edge.
  task automatic step(input logic rn, input logic [2:0] m, input logic [W-1:0] dv,
                      input logic sl, input logic sr);
    reset_n = rn;
    mode    = m;
    d       = dv;
    si_l    = sl;
    si_r    = sr;
    @(posedge en);
    #1;
  endtask

  logic [7:0] sor_exp;
  logic [7:0] sil_seq;

  initial begin
    reset_n = 1'b1; mode = HOLD; d = '0; si_l = 1'b0; si_r = 1'b0;
    sor_exp = 8'b1011_0010;  // SO_R before edge k is bit k
    sil_seq = 8'b1100_1010;  // SI_L fed MSB first

    // 1: reset and CLR
    step(1'b0, SHL, 8'hFF, 1'b1, 1'b1);
    chk("rst_q", q_a, 8'hA5);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_q_z", q_z, 8'h00);
    step(1'b1, CLR, 8'h3C, 1'b1, 1'b1);
    chk("clr_q", q_a, 8'hA5);
    chk("clr_cnt", cnt_a, 0);

    // 2: parallel-to-serial via SHR
    step(1'b1, LOAD, 8'b1011_0010, 1'b1, 1'b1);
    chk("load_q", q_a, 8'hB2);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("shr_so_r%0d", k), so_r_a, sor_exp[k]);
      step(1'b1, SHR, 8'h00, 1'b1, 1'b0);
    end
    chk("shr8_q", q_a, 8'h00);
    chk("shr8_cnt", cnt_a, 8);
    chk("shr8_done", done_a, 1);
    step(1'b1, SHR, 8'h00, 1'b0, 1'b0);
    chk("shr9_cnt", cnt_a, 8);
    chk("shr9_done", done_a, 1);

    // 3: rotates
    step(1'b1, LOAD, 8'h81, 1'b0, 1'b0);
    chk("load81_cnt", cnt_a, 0);
    chk("load81_done", done_a, 0);
    chk("load81_so_l", so_l_a, 1);
    step(1'b1, ROL, 8'h00, 1'b0, 1'b0);
    chk("rol_q", q_a, 8'h03);
    step(1'b1, ROR, 8'h00, 1'b1, 1'b1);
    chk("ror1_q", q_a, 8'h81);
    step(1'b1, ROR, 8'h00, 1'b1, 1'b1);
    chk("ror2_q", q_a, 8'hC0);
    chk("rot_cnt", cnt_a, 3);

    // 4: arithmetic shift right
    step(1'b1, LOAD, 8'h90, 1'b0, 1'b0);
    chk("asr_load", q_a, 8'h90);
    step(1'b1, ASR, 8'h00, 1'b0, 1'b0);
    chk("asr1", q_a, 8'hC8);
    step(1'b1, ASR, 8'h00, 1'b0, 1'b0);
    chk("asr2", q_a, 8'hE4);
    step(1'b1, ASR, 8'h00, 1'b0, 1'b0);
    chk("asr3", q_a, 8'hF2);
    step(1'b1, LOAD, 8'h70, 1'b0, 1'b1);
    step(1'b1, ASR, 8'h00, 1'b0, 1'b1);
    chk("asr_pos", q_a, 8'h38);

    // 5: serial-to-parallel via SHL on the RESET_VAL=0 instance
    step(1'b1, CLR, 8'hFF, 1'b1, 1'b1);
    chk("clr_z_q", q_z, 8'h00);
    chk("clr_z_cnt", cnt_z, 0);
    for (int k = 7; k >= 0; k--) begin
      step(1'b1, SHL, 8'hFF, sil_seq[k], 1'b1);
    end
    chk("shl_q", q_z, 8'hCA);
    chk("shl_done", done_z, 1);
    chk("shl_so_l", so_l_z, 1);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, HOLD, 8'h55, 1'b1, 1'b1);
    end
    chk("hold_q", q_z, 8'hCA);
    chk("hold_cnt", cnt_z, 8);

    // 6: reset in the middle of a sequence
    step(1'b1, LOAD, 8'hFF, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, SHL, 8'h00, 1'b0, 1'b0);
    end
    chk("mid_q", q_a, 8'hF0);
    chk("mid_cnt", cnt_a, 4);
    step(1'b0, SHL, 8'h00, 1'b1, 1'b1);
    chk("mid_rst_q", q_a, 8'hA5);
    chk("mid_rst_cnt", cnt_a, 0);
    step(1'b1, LOAD, 8'h5E, 1'b1, 1'b1);
    chk("post_load_q", q_a, 8'h5E);
    chk("post_load_cnt", cnt_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
